// File: rtl/dispatch_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_scoreboard_pkg
// Description : Shared core constants, FSM state encoding and sizing helper
//               for the instruction dispatch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_scoreboard_pkg;

    // Width of the commit ID shared with the commit stage.
    localparam int COMMIT_ID_WIDTH   = 4;

    // Channel register file addressing.
    localparam int CH_ADDR_W         = 4;
    localparam int NUM_CH            = 1 << CH_ADDR_W;

    // Default in-flight limit and the matching counter width.
    localparam int MAX_IN_FLIGHT_DEF = 8;
    localparam int IN_FLIGHT_W       = $clog2(MAX_IN_FLIGHT_DEF + 1);

    // Dispatch sequencing states.
    typedef enum logic [1:0] {
        ST_WAIT_TICK = 2'd0,
        ST_RUN       = 2'd1,
        ST_DRAIN     = 2'd2
    } disp_state_e;

    // Counter width able to hold 0..max inclusive.
    function automatic int in_flight_width(input int max_in_flight);
        return $clog2(max_in_flight + 1);
    endfunction

endpackage : dispatch_scoreboard_pkg
`default_nettype wire

// File: rtl/dispatch_scoreboard_hazard_check.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_scoreboard_hazard_check
// Description : Flags a dispatch request that touches a channel or the
//               accumulator with a write still outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_scoreboard_hazard_check
    import dispatch_scoreboard_pkg::*;
(
    input  logic [NUM_CH-1:0]    pend_ch,
    input  logic                 pend_acc,
    input  logic [CH_ADDR_W-1:0] src_a,
    input  logic [CH_ADDR_W-1:0] src_b,
    input  logic [CH_ADDR_W-1:0] dest,
    input  logic                 wr_ch,
    input  logic                 rd_acc,
    input  logic                 wr_acc,
    output logic                 hazard
);

    // RAW on either source, WAW on the destination, and any accumulator
    // access while an accumulator write is still outstanding.
    always_comb begin
        hazard = 1'b0;
        if (pend_ch[src_a])                 hazard = 1'b1;
        if (pend_ch[src_b])                 hazard = 1'b1;
        if (wr_ch && pend_ch[dest])         hazard = 1'b1;
        if ((rd_acc || wr_acc) && pend_acc) hazard = 1'b1;
    end

endmodule : dispatch_scoreboard_hazard_check
`default_nettype wire

// File: rtl/dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_scoreboard
// Description : In-order dispatch scoreboard. Tracks outstanding channel and
//               accumulator writes, bounds instructions in flight, assigns
//               commit IDs and sequences one program per sample tick.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_scoreboard
    import dispatch_scoreboard_pkg::*;
#(
    parameter int MAX_IN_FLIGHT = MAX_IN_FLIGHT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sample_tick,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [CH_ADDR_W-1:0]       disp_src_a,
    input  logic [CH_ADDR_W-1:0]       disp_src_b,
    input  logic [CH_ADDR_W-1:0]       disp_dest,
    input  logic                       disp_wr_ch,
    input  logic                       disp_rd_acc,
    input  logic                       disp_wr_acc,
    input  logic                       disp_last,
    output logic [COMMIT_ID_WIDTH-1:0] disp_commit_id,
    input  logic                       commit_advance,
    input  logic                       wb_ch_en,
    input  logic [CH_ADDR_W-1:0]       wb_ch_addr,
    input  logic                       wb_acc_en,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int             IFW        = in_flight_width(MAX_IN_FLIGHT);
    localparam logic [IFW-1:0] MAX_IF     = IFW'(MAX_IN_FLIGHT);
    localparam logic [IFW-1:0] IF_ONE     = IFW'(1);

    disp_state_e                state_q,     state_d;
    logic [COMMIT_ID_WIDTH-1:0] alloc_id_q,  alloc_id_d;
    logic [IFW-1:0]             in_flight_q, in_flight_d;
    logic [NUM_CH-1:0]          pend_ch_q,   pend_ch_d;
    logic                       pend_acc_q,  pend_acc_d;
    logic                       overrun_q,   overrun_d;

    logic hazard;
    logic issue;
    logic drained;

    // Hazards are judged against registered pending bits only, so a
    // writeback this cycle releases the stall one cycle later.
    dispatch_scoreboard_hazard_check u_hazard_check (
        .pend_ch  (pend_ch_q),
        .pend_acc (pend_acc_q),
        .src_a    (disp_src_a),
        .src_b    (disp_src_b),
        .dest     (disp_dest),
        .wr_ch    (disp_wr_ch),
        .rd_acc   (disp_rd_acc),
        .wr_acc   (disp_wr_acc),
        .hazard   (hazard)
    );

    // Dispatch acceptance and handshake outputs.
    always_comb begin
        disp_ready     = (state_q == ST_RUN) && enable && !sample_tick &&
                         (in_flight_q < MAX_IF) && !hazard;
        issue          = disp_valid && disp_ready;
        drained        = (in_flight_q == '0) && (pend_ch_q == '0) && !pend_acc_q;
        disp_commit_id = alloc_id_q;
        overrun        = overrun_q;
    end

    // Tracking state: ID allocation, in-flight count, pending writes, errors.
    always_comb begin
        alloc_id_d  = alloc_id_q;
        in_flight_d = in_flight_q;
        pend_ch_d   = pend_ch_q;
        pend_acc_d  = pend_acc_q;
        overrun_d   = overrun_q;
        if (enable) begin
            if (issue) alloc_id_d = alloc_id_q + 1'b1;

            if (issue && !commit_advance) begin
                in_flight_d = in_flight_q + IF_ONE;
            end else if (!issue && commit_advance) begin
                if (in_flight_q == '0) overrun_d   = 1'b1;
                else                   in_flight_d = in_flight_q - IF_ONE;
            end

            // Clears first so a simultaneous set of the same bit wins.
            if (wb_ch_en)             pend_ch_d[wb_ch_addr] = 1'b0;
            if (wb_acc_en)            pend_acc_d            = 1'b0;
            if (issue && disp_wr_ch)  pend_ch_d[disp_dest]  = 1'b1;
            if (issue && disp_wr_acc) pend_acc_d            = 1'b1;

            // A new sample arriving before the program has drained is lost.
            if (sample_tick && (state_q != ST_WAIT_TICK)) overrun_d = 1'b1;
        end
    end

    // Frame sequencing: wait for a sample, dispatch a program, drain it.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        if (enable) begin
            case (state_q)
                ST_WAIT_TICK: begin
                    if (sample_tick) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!sample_tick && issue && disp_last) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!sample_tick && drained) begin
                        state_d    = ST_WAIT_TICK;
                        frame_done = 1'b1;
                    end
                end
                default: state_d = ST_WAIT_TICK;
            endcase
        end
    end

    // State registers; alloc_id is never cleared between frames so it stays
    // aligned with the commit stage, which shares this reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT_TICK;
            alloc_id_q  <= '0;
            in_flight_q <= '0;
            pend_ch_q   <= '0;
            pend_acc_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alloc_id_q  <= alloc_id_d;
            in_flight_q <= in_flight_d;
            pend_ch_q   <= pend_ch_d;
            pend_acc_q  <= pend_acc_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule : dispatch_scoreboard
`default_nettype wire

// File: tb/tb_dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_scoreboard
// Description : Directed scoreboard bench for dispatch_scoreboard. Stimulus
//               queues the expected output values of each cycle; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_scoreboard;
    import dispatch_scoreboard_pkg::*;

    localparam int SIG_READY = 0;
    localparam int SIG_ID    = 1;
    localparam int SIG_FDONE = 2;
    localparam int SIG_OVR   = 3;

    logic                       clk = 1'b1;
    logic                       reset;
    logic                       enable;
    logic                       sample_tick;
    logic                       disp_valid;
    logic                       disp_ready;
    logic [CH_ADDR_W-1:0]       disp_src_a;
    logic [CH_ADDR_W-1:0]       disp_src_b;
    logic [CH_ADDR_W-1:0]       disp_dest;
    logic                       disp_wr_ch;
    logic                       disp_rd_acc;
    logic                       disp_wr_acc;
    logic                       disp_last;
    logic [COMMIT_ID_WIDTH-1:0] disp_commit_id;
    logic                       commit_advance;
    logic                       wb_ch_en;
    logic [CH_ADDR_W-1:0]       wb_ch_addr;
    logic                       wb_acc_en;
    logic                       frame_done;
    logic                       overrun;

    typedef struct {
        string name;
        int    sig;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   act;
    int   n_checks = 0;
    int   n_errors = 0;

    dispatch_scoreboard #(.MAX_IN_FLIGHT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_tick    (sample_tick),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_src_a     (disp_src_a),
        .disp_src_b     (disp_src_b),
        .disp_dest      (disp_dest),
        .disp_wr_ch     (disp_wr_ch),
        .disp_rd_acc    (disp_rd_acc),
        .disp_wr_acc    (disp_wr_acc),
        .disp_last      (disp_last),
        .disp_commit_id (disp_commit_id),
        .commit_advance (commit_advance),
        .wb_ch_en       (wb_ch_en),
        .wb_ch_addr     (wb_ch_addr),
        .wb_acc_en      (wb_acc_en),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued during a cycle is compared at its
    // falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sig)
                SIG_READY: act = int'(disp_ready);
                SIG_ID:    act = int'(disp_commit_id);
                SIG_FDONE: act = int'(frame_done);
                default:   act = int'(overrun);
            endcase
            n_checks++;
            if (act !== e.val) begin
                n_errors++;
                $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.val, $time);
            end
        end
    end

    task automatic chk(input string name, input int sig, input int val);
        exp_t x;
        x.name = name;
        x.sig  = sig;
        x.val  = val;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        sample_tick    = 1'b0;
        disp_valid     = 1'b0;
        disp_src_a     = '0;
        disp_src_b     = '0;
        disp_dest      = '0;
        disp_wr_ch     = 1'b0;
        disp_rd_acc    = 1'b0;
        disp_wr_acc    = 1'b0;
        disp_last      = 1'b0;
        commit_advance = 1'b0;
        wb_ch_en       = 1'b0;
        wb_ch_addr     = '0;
        wb_acc_en      = 1'b0;
    endtask

    task automatic disp(input logic v, input int a, input int b, input int d,
                        input logic wch, input logic racc, input logic wacc,
                        input logic last);
        disp_valid  = v;
        disp_src_a  = CH_ADDR_W'(a);
        disp_src_b  = CH_ADDR_W'(b);
        disp_dest   = CH_ADDR_W'(d);
        disp_wr_ch  = wch;
        disp_rd_acc = racc;
        disp_wr_acc = wacc;
        disp_last   = last;
    endtask

    task automatic wb_ch(input int addr);
        wb_ch_en   = 1'b1;
        wb_ch_addr = CH_ADDR_W'(addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        idle();
        disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_ready", SIG_READY, 0);
        chk("reset_overrun", SIG_OVR, 0);
        chk("reset_fdone", SIG_FDONE, 0);
        chk("reset_id", SIG_ID, 0);
        step();

        // First enabled tick opens the frame.
        reset = 1'b0;
        idle(); sample_tick = 1'b1;
        chk("wait_ready", SIG_READY, 0);
        step();
        idle();
        chk("run_ready", SIG_READY, 1);
        chk("run_id0", SIG_ID, 0);
        step();

        // RAW stall on channel 3, released the cycle after its writeback.
        idle(); disp(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("issue_wr3_ready", SIG_READY, 1);
        chk("issue_wr3_id", SIG_ID, 0);
        step();
        idle(); disp(1'b1, 3, 4, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("raw3_stall", SIG_READY, 0);
        step();
        idle(); disp(1'b1, 3, 4, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        wb_ch(3); commit_advance = 1'b1;
        chk("raw3_no_bypass", SIG_READY, 0);
        step();
        idle(); disp(1'b1, 3, 4, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("raw3_release", SIG_READY, 1);
        chk("raw3_release_id", SIG_ID, 1);
        step();
        idle(); commit_advance = 1'b1;
        chk("idle_ready", SIG_READY, 1);
        step();

        // Set and clear of channel 7 together: the set wins.
        idle(); disp(1'b1, 0, 0, 7, 1'b1, 1'b0, 1'b0, 1'b0); wb_ch(7);
        chk("setclr7_ready", SIG_READY, 1);
        chk("setclr7_id", SIG_ID, 2);
        step();
        idle(); disp(1'b1, 7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        wb_ch(7); commit_advance = 1'b1;
        chk("setclr7_pending", SIG_READY, 0);
        step();
        idle(); disp(1'b0, 7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ch7_released", SIG_READY, 1);
        chk("ch7_released_id", SIG_ID, 3);
        step();

        // Accumulator hazard.
        idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wacc_ready", SIG_READY, 1);
        chk("wacc_id", SIG_ID, 3);
        step();
        idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        wb_acc_en = 1'b1; commit_advance = 1'b1;
        chk("racc_stall", SIG_READY, 0);
        step();
        idle(); disp(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("racc_release", SIG_READY, 1);
        step();

        // Fill to the in-flight limit.
        for (int i = 0; i < 8; i++) begin
            idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("fill_ready_%0d", i), SIG_READY, 1);
            chk($sformatf("fill_id_%0d", i), SIG_ID, 4 + i);
            step();
        end
        idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); commit_advance = 1'b1;
        chk("full_stall", SIG_READY, 0);
        chk("full_id", SIG_ID, 12);
        step();
        idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_release", SIG_READY, 1);
        chk("full_release_id", SIG_ID, 12);
        step();
        idle(); commit_advance = 1'b1;
        chk("full_again", SIG_READY, 0);
        step();
        for (int i = 0; i < 7; i++) begin
            idle(); commit_advance = 1'b1;
            step();
        end

        // Issue together with commit_advance holds in_flight; ID wraps.
        for (int i = 0; i < 7; i++) begin
            idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); commit_advance = 1'b1;
            chk($sformatf("wrap_ready_%0d", i), SIG_READY, 1);
            chk($sformatf("wrap_id_%0d", i), SIG_ID, (13 + i) % 16);
            step();
        end
        idle();
        chk("no_overrun_yet", SIG_OVR, 0);
        chk("wrap_next_id", SIG_ID, 4);
        step();

        // Last instruction with two in flight, then drain.
        idle(); disp(1'b1, 0, 0, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("drain_i0_id", SIG_ID, 4);
        step();
        idle(); disp(1'b1, 0, 0, 10, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("last_ready", SIG_READY, 1);
        chk("last_id", SIG_ID, 5);
        step();
        idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        commit_advance = 1'b1; wb_ch(9);
        chk("drain_ready", SIG_READY, 0);
        chk("drain_fdone0", SIG_FDONE, 0);
        step();
        idle(); commit_advance = 1'b1; wb_ch(10);
        chk("drain_fdone1", SIG_FDONE, 0);
        step();
        idle();
        chk("frame_done", SIG_FDONE, 1);
        chk("frame_done_ready", SIG_READY, 0);
        step();
        idle();
        chk("frame_done_single", SIG_FDONE, 0);
        chk("wait_again_ready", SIG_READY, 0);
        step();
        idle(); sample_tick = 1'b1;
        chk("tick2_ready", SIG_READY, 0);
        step();
        idle();
        chk("run2_ready", SIG_READY, 1);
        chk("run2_id_kept", SIG_ID, 6);
        step();

        // Tick during RUN raises sticky overrun and stays in RUN.
        idle(); sample_tick = 1'b1; disp_valid = 1'b1;
        chk("run_tick_ready", SIG_READY, 0);
        chk("run_tick_ovr_pre", SIG_OVR, 0);
        step();
        idle();
        chk("run_tick_ovr", SIG_OVR, 1);
        chk("run_tick_still_run", SIG_READY, 1);
        step();
        idle();
        chk("ovr_sticky", SIG_OVR, 1);
        step();

        // Mid-frame reset discards everything.
        idle(); reset = 1'b1;
        chk("reset2_ovr", SIG_OVR, 0);
        chk("reset2_ready", SIG_READY, 0);
        chk("reset2_id", SIG_ID, 0);
        step();
        reset = 1'b0;

        // commit_advance with nothing in flight: overrun, count saturates.
        idle(); commit_advance = 1'b1;
        chk("underflow_pre", SIG_OVR, 0);
        step();
        idle(); sample_tick = 1'b1;
        chk("underflow_ovr", SIG_OVR, 1);
        step();
        for (int i = 0; i < 8; i++) begin
            idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("sat_ready_%0d", i), SIG_READY, 1);
            chk($sformatf("sat_id_%0d", i), SIG_ID, i);
            step();
        end
        idle(); disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_full", SIG_READY, 0);
        step();

        // Disabled: no ready and commit_advance is ignored.
        idle(); enable = 1'b0; disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        commit_advance = 1'b1;
        chk("disabled_ready", SIG_READY, 0);
        step();
        idle(); enable = 1'b1; disp(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("enable_hold", SIG_READY, 0);
        step();
        idle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dispatch_scoreboard
`default_nettype wire
